// File: rtl/ser_rx_ctrl_pkg.sv
// Shared definitions for the serial receive controller: frame FSM encoding,
// word width and divider range.
package ser_rx_ctrl_pkg;

  localparam int NBITS       = 16;
  localparam int BIT_CNT_W   = $clog2(NBITS);
  localparam int CLK_DIV_MIN = 1;
  localparam int CLK_DIV_MAX = 255;
  localparam int DIV_CNT_W   = $clog2(CLK_DIV_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TRAIL = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // The serial clock only runs while a frame is on the wire.
  function automatic logic div_active(input state_t s);
    return (s == ST_LEAD) || (s == ST_SHIFT) || (s == ST_TRAIL);
  endfunction

endpackage

// File: rtl/ser_rx_ctrl_sclk_div.sv
// Clock divider: double-rate serial clock, its one-clk delayed copy and the
// half-rate link clock. Held at zero whenever the enable is low.
module ser_rx_ctrl_sclk_div
  import ser_rx_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic i_async_rst,
  input  logic i_sync_rst,
  input  logic i_en,
  output logic o_dbl_sclk,
  output logic o_dbl_sclk_d,
  output logic o_sclk_out
);

  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CLK_DIV - 1);

  logic [DIV_CNT_W-1:0] r_div_cnt;
  logic                 r_dbl_sclk;
  logic                 r_dbl_sclk_d;
  logic                 r_sclk_out;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain r_dbl_sclk_d onto
  // the freshly toggled r_dbl_sclk within one edge.
  always_ff @(posedge clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      r_div_cnt    <= '0;
      r_dbl_sclk   <= 1'b0;
      r_dbl_sclk_d <= 1'b0;
      r_sclk_out   <= 1'b0;
    end else if (i_sync_rst) begin
      r_div_cnt    <= '0;
      r_dbl_sclk   <= 1'b0;
      r_dbl_sclk_d <= 1'b0;
      r_sclk_out   <= 1'b0;
    end else begin
      r_dbl_sclk_d <= r_dbl_sclk;
      if (!i_en) begin
        r_div_cnt  <= '0;
        r_dbl_sclk <= 1'b0;
        r_sclk_out <= 1'b0;
      end else if (r_div_cnt == DIV_LAST) begin
        r_div_cnt  <= '0;
        r_dbl_sclk <= ~r_dbl_sclk;
        // Link clock advances only on the rising toggle of dbl_sclk.
        if (!r_dbl_sclk) r_sclk_out <= ~r_sclk_out;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

  assign o_dbl_sclk   = r_dbl_sclk;
  assign o_dbl_sclk_d = r_dbl_sclk_d;
  assign o_sclk_out   = r_sclk_out;

endmodule

// File: rtl/ser_rx_ctrl.sv
// Frame timing controller for the serial-to-parallel converter: drives the
// link clock and select, synchronises the data pin and frames NBITS bits.
module ser_rx_ctrl
  import ser_rx_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input  logic clk,
  input  logic async_rst,
  input  logic sync_rst,
  input  logic start,
  input  logic ser_din,
  output logic sclk_out,
  output logic cs_n,
  output logic dbl_sclk,
  output logic dbl_sclk_d,
  output logic ser2par_en,
  output logic ser_in,
  output logic busy,
  output logic done
);

  localparam int                   GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(NBITS - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic                  r_done;
  logic                  r_sync1;
  logic                  r_ser_in;
  logic                  w_fe;
  logic                  w_div_en;

  // Enabling from the next state keeps the divider at zero on the first
  // GAP cycle instead of letting it toggle once more on the way out.
  assign w_div_en = div_active(w_state_nxt);

  ser_rx_ctrl_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .clk          (clk),
    .i_async_rst  (async_rst),
    .i_sync_rst   (sync_rst),
    .i_en         (w_div_en),
    .o_dbl_sclk   (dbl_sclk),
    .o_dbl_sclk_d (dbl_sclk_d),
    .o_sclk_out   (sclk_out)
  );

  assign w_fe = !dbl_sclk && dbl_sclk_d;

  // NOTE: every signal written here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    cs_n        = 1'b0;
    ser2par_en  = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        cs_n = 1'b1;
        busy = 1'b0;
        if (start) w_state_nxt = ST_LEAD;
      end
      ST_LEAD:  if (w_fe) w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        ser2par_en = 1'b1;
        if (w_fe && (r_bit_cnt == BIT_LAST)) w_state_nxt = ST_TRAIL;
      end
      ST_TRAIL: if (w_fe) w_state_nxt = ST_GAP;
      ST_GAP: begin
        cs_n = 1'b1;
        if (r_gap_cnt == GAP_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sync_rst is tested before any other input so it overrides start
  // and aborts a frame in flight without a done pulse.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_done    <= 1'b0;
    end else if (sync_rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == ST_TRAIL) && w_fe;
      if ((r_state == ST_SHIFT) && w_fe)
        r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
      if (r_state == ST_GAP)
        r_gap_cnt <= (r_gap_cnt == GAP_LAST) ? '0 : r_gap_cnt + 1'b1;
      else
        r_gap_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_sync1  <= 1'b0;
      r_ser_in <= 1'b0;
    end else if (sync_rst) begin
      r_sync1  <= 1'b0;
      r_ser_in <= 1'b0;
    end else begin
      r_sync1  <= ser_din;
      r_ser_in <= r_sync1;
    end
  end

  assign ser_in = r_ser_in;
  assign done   = r_done;

endmodule

// File: doc/ser_rx_ctrl.md
Name: ser_rx_ctrl

Overview:
Upstream timing and framing controller for the serial-to-parallel converter. It divides the system clock into the double-rate serial clock and its one-cycle-delayed copy, and drives the external two-wire link (sclk_out, cs_n). It synchronises the incoming data pin and runs a frame FSM that asserts ser2par_en for exactly NBITS falling edges of dbl_sclk. A start/busy/done handshake faces the host logic.

Parameters:
CLK_DIV, 4, clk cycles per dbl_sclk half-period (legal range 1..255)
NBITS, 16, bits per frame; fixed at 16 to match the downstream converter
GAP_CYC, 8, idle clk cycles forced between frames (cs_n high), minimum 1

Ports:
clk  in  1  system clock
async_rst  in  1  asynchronous reset, active-high
sync_rst  in  1  synchronous reset, active-high, dominates all other inputs
start  in  1  request one frame; sampled only in IDLE
ser_din  in  1  raw serial data pin (asynchronous)
sclk_out  out  1  serial clock to the external device
cs_n  out  1  frame select to the external device, active-low
dbl_sclk  out  1  double-rate serial clock to the converter
dbl_sclk_d  out  1  dbl_sclk delayed by one clk
ser2par_en  out  1  conversion enable to the converter
ser_in  out  1  synchronised serial data to the converter
busy  out  1  high while state != IDLE
done  out  1  one-clk pulse at frame end

Behaviour:
- Reset (async or sync) values: state=IDLE, div_cnt=0, bit_cnt=0, gap_cnt=0; all outputs 0 except cs_n=1. async_rst acts immediately. sync_rst acts at the next clk edge. Reset mid-frame aborts the frame with no done pulse.
- ser_in is the output of a 2-flop synchroniser on ser_din, free-running outside reset; latency 2 clk.
- Divider: active only in LEAD, SHIFT and TRAIL; in all other states div_cnt and dbl_sclk are held at 0.
  - div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and dbl_sclk toggles.
- dbl_sclk_d is dbl_sclk registered every clk, unconditionally.
- fe (internal) = dbl_sclk==0 && dbl_sclk_d==1. This is the same one-clk pulse the converter uses.
- sclk_out toggles on every dbl_sclk rising toggle while the divider is active; it is forced to 0 otherwise. Period of sclk_out = 4*CLK_DIV clk.
- FSM:
  - IDLE: cs_n=1. On start=1, go to LEAD, cs_n becomes 0 on the next cycle.
  - LEAD: cs_n=0, ser2par_en=0. Go to SHIFT on the first fe.
  - SHIFT: ser2par_en=1, bit_cnt increments on each fe. On the fe where bit_cnt==NBITS-1, clear bit_cnt and go to TRAIL. ser2par_en is therefore high on exactly NBITS fe pulses and drops the cycle after the last one.
  - TRAIL: ser2par_en=0, cs_n=0. On the next fe, go to GAP, assert done for that one cycle, set cs_n=1.
  - GAP: counts GAP_CYC clk cycles, then returns to IDLE. start is ignored here.
- start while busy is ignored; there is no queueing.
- start held high continuously produces back-to-back frames separated by GAP plus one IDLE cycle.
- Simultaneous sync_rst and start: reset wins and the FSM stays in IDLE.
- done coincides with the converter's valid having been high for at least 2*CLK_DIV clk.

Decomposition:
- Shared package: state encoding (IDLE, LEAD, SHIFT, TRAIL, GAP as 3-bit localparams), NBITS=16 word-width constant, CLK_DIV legal-range constants.
- One sub-module is natural: sclk_div (divider producing dbl_sclk, dbl_sclk_d and sclk_out, with an enable input).
- The FSM and the synchroniser stay in ser_rx_ctrl.

Test Plan:
- CLK_DIV=2, GAP_CYC=8, reset released, start pulsed once:
  - cs_n falls 1 clk later.
  - ser2par_en is high on exactly 16 fe pulses.
  - done pulses once.
  - cs_n returns high; busy drops 8 clk after done.
- Pin pattern 0xA5C3 driven MSB-first, changing on sclk_out rising edges, with the converter attached -> converter par_out=0xA5C3 with valid=1 at done.
- start pulses during SHIFT and during GAP -> no extra frame, bit_cnt unaffected, exactly one done.
- async_rst asserted at bit 7 of SHIFT:
  - All outputs reset in the same cycle (cs_n=1, dbl_sclk=0).
  - No done pulse.
  - The next start produces a full 16-bit frame.
- sync_rst and start high in the same cycle from IDLE -> FSM stays in IDLE, busy=0. With start held high after release, frames repeat with a gap of GAP_CYC+1 clk.
- CLK_DIV=1 -> dbl_sclk toggles every clk, fe spacing 2 clk, sclk_out period 4 clk, still exactly 16 enabled fe pulses.
